dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin two-port arbiter onto a single DRAM command port with timeout abort
module dram_arbiter #(
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [1:0]            grant,
    output logic                  timeout_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                  state_q;
    logic                    last_q, req_q, we_q, ack0_q, ack1_q, busy_q, err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rd0_q, rd1_q, rd_d;
    logic [1:0]              gnt_q;
    logic [15:0]             cnt_q;
    logic                    sel_d, tmo_d;
    // last_q holds the requester granted most recently; a tie goes to the other one
    assign sel_d = (r0_req && r1_req) ? ~last_q : r1_req;
    assign tmo_d = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    assign rd_d  = mem_ack ? mem_rdata : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (r0_req || r1_req) begin
                    state_q <= WAIT;
                    last_q  <= sel_d;
                    gnt_q   <= sel_d ? 2'b10 : 2'b01;
                    we_q    <= sel_d ? r1_we : r0_we;
                    addr_q  <= sel_d ? r1_addr : r0_addr;
                    wdata_q <= sel_d ? r1_wdata : r0_wdata;
                    req_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                end
                WAIT: if (mem_ack || tmo_d) begin
                    state_q <= RESP;
                    req_q   <= 1'b0;
                    ack0_q  <= gnt_q[0];
                    ack1_q  <= gnt_q[1];
                    if (gnt_q[0]) rd0_q <= rd_d;
                    if (gnt_q[1]) rd1_q <= rd_d;
                    if (!mem_ack) err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                RESP: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign r0_ack      = ack0_q;
    assign r1_ack      = ack1_q;
    assign r0_rdata    = rd0_q;
    assign r1_rdata    = rd1_q;
    assign grant       = gnt_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
endmodule
